// File: rtl/bcd_7seg_scan_driver.sv
// ---------------------------------------------------------------------------
// bcd_7seg_scan_driver
//
// Purpose:
//   Captures NDIG packed BCD digits plus decimal points into a shadow register
//   and drives a time-multiplexed common-anode 7-segment display, one digit
//   per slot. Each slot begins with BLANK_CYCLES clocks of all-off output to
//   suppress ghosting. The shadow is copied into the display registers only
//   at frame boundaries, so a digit never shows a mix of old and new data.
//   frame_done pulses for one clock at the start of every frame.
//
// Optional feature (compile-time macro LZB_EN):
//   When LZB_EN is defined, leading zeros are blanked. Digit i>0 stays dark
//   when it and every higher digit are 0 with no decimal point set. Digit 0
//   is always shown. Blanked digits keep their slot timing.
//   When LZB_EN is undefined, every digit is always shown.
//
// Parameters:
//   NDIG         number of digits, 1..8
//   REFRESH_DIV  clocks per digit slot, must exceed BLANK_CYCLES
//   BLANK_CYCLES all-off clocks at the start of each slot, >= 1
//
// Ports:
//   clock       in   1        system clock, rising edge
//   reset       in   1        asynchronous, active-low
//   load        in   1        capture strobe for digits_in/dp_in (level-sampled)
//   digits_in   in   4*NDIG   packed BCD, digit i = [4i+3:4i], digit 0 rightmost
//   dp_in       in   NDIG     decimal point per digit, 1 = lit
//   seg_n       out  7        {g,f,e,d,c,b,a}, active-low
//   dp_n        out  1        decimal point, active-low
//   an_n        out  NDIG     digit anodes, active-low
//   frame_done  out  1        one-clock pulse at the start of each frame
// ---------------------------------------------------------------------------
module bcd_7seg_scan_driver #(
    parameter int NDIG         = 4,
    parameter int REFRESH_DIV  = 4,
    parameter int BLANK_CYCLES = 1
) (
    input  logic                clock,
    input  logic                reset,
    input  logic                load,
    input  logic [4*NDIG-1:0]   digits_in,
    input  logic [NDIG-1:0]     dp_in,
    output logic [6:0]          seg_n,
    output logic                dp_n,
    output logic [NDIG-1:0]     an_n,
    output logic                frame_done
);

    localparam int PCNT_W = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
    localparam int IDX_W  = (NDIG > 1) ? $clog2(NDIG) : 1;

    localparam logic [PCNT_W-1:0] PCNT_LAST  = PCNT_W'(REFRESH_DIV - 1);
    localparam logic [PCNT_W-1:0] BLANK_LAST = PCNT_W'(BLANK_CYCLES - 1);
    localparam logic [IDX_W-1:0]  IDX_LAST   = IDX_W'(NDIG - 1);

    typedef enum logic {
        ST_BLANK = 1'b0,
        ST_SHOW  = 1'b1
    } state_t;

    // Scan position and slot phase
    logic [PCNT_W-1:0]      pcnt_q, pcnt_d;
    logic [IDX_W-1:0]       idx_q, idx_d;
    state_t                 state_q, state_d;

    // Shadow (written by load) and display (copied at frame boundary) data
    logic [NDIG-1:0][3:0]   shadow_dig_q;
    logic [NDIG-1:0]        shadow_dp_q;
    logic [NDIG-1:0][3:0]   disp_dig_q;
    logic [NDIG-1:0]        disp_dp_q;

    // Registered outputs
    logic [6:0]             seg_n_q, seg_n_d;
    logic                   dp_n_q, dp_n_d;
    logic [NDIG-1:0]        an_n_q, an_n_d;
    logic                   frame_done_q, frame_done_d;

    logic                   slot_wrap;
    logic                   frame_wrap;
    logic [NDIG-1:0]        blank_vec;

    function automatic logic [6:0] decode_bcd(input logic [3:0] d);
        logic [6:0] s;
        case (d)
            4'd0:    s = 7'b1000000;
            4'd1:    s = 7'b1111001;
            4'd2:    s = 7'b0100100;
            4'd3:    s = 7'b0110000;
            4'd4:    s = 7'b0011001;
            4'd5:    s = 7'b0010010;
            4'd6:    s = 7'b0000010;
            4'd7:    s = 7'b1111000;
            4'd8:    s = 7'b0000000;
            4'd9:    s = 7'b0010000;
            default: s = 7'b0111111;   // non-BCD nibble shows a dash
        endcase
        return s;
    endfunction

`ifdef LZB_EN
    // A digit is a leading zero when it and every digit above it are 0 with
    // no decimal point. Each bit is an independent reduction over the upper
    // slice, which keeps the logic free of combinational chains.
    assign blank_vec[0] = 1'b0;
    for (genvar gi = 1; gi < NDIG; gi++) begin : g_lzb
        assign blank_vec[gi] = ~(|disp_dig_q[NDIG-1:gi]) & ~(|disp_dp_q[NDIG-1:gi]);
    end
`else
    assign blank_vec = '0;
`endif

    assign slot_wrap  = (pcnt_q == PCNT_LAST);
    assign frame_wrap = slot_wrap && (idx_q == IDX_LAST);

    always_comb begin
        pcnt_d       = slot_wrap ? '0 : pcnt_q + 1'b1;
        idx_d        = idx_q;
        if (slot_wrap) begin
            idx_d = (idx_q == IDX_LAST) ? '0 : idx_q + 1'b1;
        end

        state_d = state_q;
        case (state_q)
            ST_BLANK: if (pcnt_q == BLANK_LAST) state_d = ST_SHOW;
            ST_SHOW:  if (slot_wrap)            state_d = ST_BLANK;
            default:                            state_d = ST_BLANK;
        endcase

        frame_done_d = frame_wrap;

        // Outputs follow the current scan position one clock later
        seg_n_d = 7'h7F;
        dp_n_d  = 1'b1;
        an_n_d  = '1;
        if (state_q == ST_SHOW && !blank_vec[idx_q]) begin
            an_n_d[idx_q] = 1'b0;
            seg_n_d       = decode_bcd(disp_dig_q[idx_q]);
            dp_n_d        = ~disp_dp_q[idx_q];
        end
    end

    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            pcnt_q       <= '0;
            idx_q        <= '0;
            state_q      <= ST_BLANK;
            shadow_dig_q <= '0;
            shadow_dp_q  <= '0;
            disp_dig_q   <= '0;
            disp_dp_q    <= '0;
            seg_n_q      <= 7'h7F;
            dp_n_q       <= 1'b1;
            an_n_q       <= '1;
            frame_done_q <= 1'b0;
        end else begin
            pcnt_q       <= pcnt_d;
            idx_q        <= idx_d;
            state_q      <= state_d;
            seg_n_q      <= seg_n_d;
            dp_n_q       <= dp_n_d;
            an_n_q       <= an_n_d;
            frame_done_q <= frame_done_d;

            if (load) begin
                shadow_dig_q <= digits_in;
                shadow_dp_q  <= dp_in;
            end
            // Display takes the shadow as it was before this edge, so a load
            // coinciding with the boundary appears one frame later.
            if (frame_wrap) begin
                disp_dig_q <= shadow_dig_q;
                disp_dp_q  <= shadow_dp_q;
            end
        end
    end

    assign seg_n      = seg_n_q;
    assign dp_n       = dp_n_q;
    assign an_n       = an_n_q;
    assign frame_done = frame_done_q;

endmodule

// File: tb/tb_bcd_7seg_scan_driver.sv
module tb_bcd_7seg_scan_driver;

    localparam int NDIG = 4;

    logic        clock = 1'b0;
    logic        reset = 1'b0;
    logic        load  = 1'b0;
    logic [15:0] digits_in = 16'h0;
    logic [3:0]  dp_in = 4'h0;
    logic [6:0]  seg_n;
    logic        dp_n;
    logic [3:0]  an_n;
    logic        frame_done;

    bcd_7seg_scan_driver #(
        .NDIG        (4),
        .REFRESH_DIV (4),
        .BLANK_CYCLES(1)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .load       (load),
        .digits_in  (digits_in),
        .dp_in      (dp_in),
        .seg_n      (seg_n),
        .dp_n       (dp_n),
        .an_n       (an_n),
        .frame_done (frame_done)
    );

    always #5 clock = ~clock;

    typedef struct packed {
        logic [3:0] an;
        logic [6:0] seg;
        logic       dp;
    } exp_t;

    exp_t exp_q[$];

    int checks = 0;
    int errors = 0;
    int k      = 0;          // rising edges since the last reset release
    bit mon_en   = 1'b0;
    bit end_req  = 1'b0;
    bit mon_done = 1'b0;

    // Bench model of shadow and displayed data
    logic [15:0] sh_dig = 16'h0;
    logic [3:0]  sh_dp  = 4'h0;
    logic [15:0] md_dig = 16'h0;
    logic [3:0]  md_dp  = 4'h0;

    function automatic logic [6:0] seg_of(input logic [3:0] d);
        case (d)
            4'd0:    return 7'b1000000;
            4'd1:    return 7'b1111001;
            4'd2:    return 7'b0100100;
            4'd3:    return 7'b0110000;
            4'd4:    return 7'b0011001;
            4'd5:    return 7'b0010010;
            4'd6:    return 7'b0000010;
            4'd7:    return 7'b1111000;
            4'd8:    return 7'b0000000;
            4'd9:    return 7'b0010000;
            default: return 7'b0111111;
        endcase
    endfunction

    // Queue the lit slots of the frame that starts now
    task automatic push_frame();
        for (int i = 0; i < NDIG; i++) begin
            logic [3:0] d;
            bit         blank;
            exp_t       e;
            d     = md_dig[4*i +: 4];
            blank = 1'b0;
`ifdef LZB_EN
            if (i > 0 && (md_dig >> (4*i)) == 16'h0 && (md_dp >> i) == 4'h0) blank = 1'b1;
`endif
            if (!blank) begin
                e.an    = 4'hF;
                e.an[i] = 1'b0;
                e.seg   = seg_of(d);
                e.dp    = ~md_dp[i];
                exp_q.push_back(e);
            end
        end
        $display("[%0t] frame queued: digits=%h dp=%b", $time, md_dig, md_dp);
    endtask

    task automatic step();
        @(posedge clock);
        k++;
        if (k % 16 == 0) begin
            md_dig = sh_dig;
            md_dp  = sh_dp;
        end
        if (load) begin
            sh_dig = digits_in;
            sh_dp  = dp_in;
        end
        @(negedge clock);
        load = 1'b0;
        if (k % 16 == 0) push_frame();
    endtask

    task automatic load_at(input int kk, input logic [15:0] d, input logic [3:0] p);
        while (k < kk - 1) step();
        digits_in = d;
        dp_in     = p;
        load      = 1'b1;
        $display("[%0t] load digits=%h dp=%b at edge %0d", $time, d, p, kk);
        step();
    endtask

    task automatic release_reset();
        reset  = 1'b1;
        k      = 0;
        sh_dig = 16'h0;
        sh_dp  = 4'h0;
        md_dig = 16'h0;
        md_dp  = 4'h0;
        exp_q.delete();
        push_frame();
        mon_en = 1'b1;
    endtask

    // Monitor: samples 1 time unit after each falling clock edge and after
    // any assertion of reset (no clock edge needed for that one).
    initial begin
        logic [3:0] prev_an;
        exp_t       cur;
        bit         exp_fd;
        prev_an = 4'hF;
        cur     = '0;
        forever begin
            @(negedge clock or negedge reset);
            #1;
            if (!reset) begin
                checks++;
                if (an_n !== 4'hF || seg_n !== 7'h7F || dp_n !== 1'b1 || frame_done !== 1'b0) begin
                    errors++;
                    $display("FAIL reset_state: an_n=%b seg_n=%b dp_n=%b frame_done=%b, want 1111 1111111 1 0",
                             an_n, seg_n, dp_n, frame_done);
                end
                prev_an = 4'hF;
            end else if (mon_en) begin
                exp_fd = (k > 0) && (k % 16 == 0);
                checks++;
                if (frame_done !== exp_fd) begin
                    errors++;
                    $display("FAIL frame_done at edge %0d: got %b, want %b", k, frame_done, exp_fd);
                end
                if (an_n !== 4'hF) begin
                    if (prev_an === 4'hF) begin
                        checks++;
                        if (exp_q.size() == 0) begin
                            errors++;
                            $display("FAIL slot_unexpected at edge %0d: an_n=%b seg_n=%b dp_n=%b, want no lit digit",
                                     k, an_n, seg_n, dp_n);
                            cur = {an_n, seg_n, dp_n};
                        end else begin
                            cur = exp_q.pop_front();
                            if (an_n !== cur.an || seg_n !== cur.seg || dp_n !== cur.dp) begin
                                errors++;
                                $display("FAIL slot at edge %0d: got an_n=%b seg_n=%b dp_n=%b, want an_n=%b seg_n=%b dp_n=%b",
                                         k, an_n, seg_n, dp_n, cur.an, cur.seg, cur.dp);
                            end else begin
                                $display("[%0t] slot an_n=%b seg_n=%b dp_n=%b ok", $time, an_n, seg_n, dp_n);
                            end
                        end
                    end else begin
                        checks++;
                        if (an_n !== cur.an || seg_n !== cur.seg || dp_n !== cur.dp) begin
                            errors++;
                            $display("FAIL slot_hold at edge %0d: got an_n=%b seg_n=%b dp_n=%b, want an_n=%b seg_n=%b dp_n=%b",
                                     k, an_n, seg_n, dp_n, cur.an, cur.seg, cur.dp);
                        end
                    end
                end else begin
                    checks++;
                    if (seg_n !== 7'h7F || dp_n !== 1'b1) begin
                        errors++;
                        $display("FAIL blank_outputs at edge %0d: seg_n=%b dp_n=%b, want 1111111 1", k, seg_n, dp_n);
                    end
                end
                prev_an = an_n;
                if (end_req && !mon_done) begin
                    checks++;
                    if (exp_q.size() != 0) begin
                        errors++;
                        $display("FAIL drain: %0d expected slots never shown, want 0", exp_q.size());
                    end
                    mon_done = 1'b1;
                end
            end
        end
    end

    initial begin
        reset = 1'b0;
        repeat (3) @(negedge clock);
        release_reset();

        load_at(3,  16'h1234, 4'b0100);   // shown in frame 1
        load_at(20, 16'h00A5, 4'b0000);   // shown in frame 2
        load_at(48, 16'h9999, 4'b0000);   // on boundary edge: frame 3 repeats 00A5, frame 4 shows 9999
        load_at(70, 16'h0070, 4'b0000);   // shown from frame 5
        while (k < 106) step();           // frame 6, slot 2 in SHOW

        mon_en = 1'b0;
        #2 reset = 1'b0;
        $display("[%0t] reset asserted mid-slot", $time);
        repeat (3) @(negedge clock);
        release_reset();
        while (k < 31) step();

        end_req = 1'b1;
        for (int i = 0; i < 4 && !mon_done; i++) @(negedge clock);
        if (!mon_done) begin
            $display("FAIL monitor_timeout: monitor did not finish, want finished");
            $fatal(1, "monitor did not finish");
        end
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
